tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, giving the width of the tick period.
REQ-002 SHALL have parameter NUM_REP_BITS, default 4, giving the width of the repeat count.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered this cycle.
REQ-006 SHALL have port cmd_ready  output  1  scheduler can accept a command this cycle.
REQ-007 SHALL have port cmd_period  input  NUM_CNT_BITS  cycles between ticks; 0 is illegal.
REQ-008 SHALL have port cmd_repeat  input  NUM_REP_BITS  number of ticks to emit; 0 is illegal.
REQ-009 SHALL have port abort  input  1  terminates the running command.
REQ-010 SHALL have port tick  output  1  one-cycle pulse per elapsed period.
REQ-011 SHALL have port busy  output  1  a command is running.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the final tick of a command.
REQ-013 SHALL have port cmd_err  output  1  one-cycle pulse when an illegal command is rejected.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-016 SHALL assert cmd_ready only in IDLE and SHALL accept a command in any cycle where cmd_valid and cmd_ready are both 1.
REQ-017 SHALL, on acceptance with cmd_period != 0 and cmd_repeat != 0, latch both fields, clear the period and tick counters, and enter RUN on the next edge.
REQ-018 SHALL, on acceptance with cmd_period == 0 or cmd_repeat == 0, remain in IDLE and pulse cmd_err in the following cycle, with no tick and no done.
REQ-019 SHALL, in RUN, increment the period counter every cycle; on the cycle it equals the latched period it wraps to 1 and tick pulses in the next cycle.
REQ-020 SHALL produce the first tick exactly P cycles after the acceptance cycle, and each later tick P cycles after the previous one (P = latched period).
REQ-021 SHALL emit a tick every cycle for P = 1 and SHALL handle P = 2^NUM_CNT_BITS-1 without overflow.
REQ-022 SHALL, after the R-th tick (R = latched repeat), enter DONE, pulse done in the cycle after that tick, and then return to IDLE, with cmd_ready = 1 in the cycle after done.
REQ-023 SHALL hold busy = 1 from the cycle after acceptance through the cycle carrying the final tick.
REQ-024 SHALL, when abort = 1 in RUN, enter IDLE on the next edge, suppress any tick due in that cycle, produce no done, and clear the counters.
REQ-025 SHALL ignore abort in IDLE and DONE, and SHALL accept a command offered in IDLE even if abort is simultaneously 1.
REQ-026 SHALL ignore cmd_valid whenever cmd_ready = 0, so that commands are neither queued nor reported as errors.

Reset
REQ-027 SHALL, while n_rst = 0, asynchronously force the FSM to IDLE, clear all counters and latched fields, and drive tick = busy = done = cmd_err = 0 and cmd_ready = 0.
REQ-028 SHALL drive cmd_ready = 1 in the first cycle after n_rst deasserts.
REQ-029 SHALL, when reset is asserted mid-command, discard the command with no done emitted afterwards.

Configuration
REQ-030 SHALL, with macro TICK_SCHED_STATUS_EN defined, add output ticks_left  NUM_REP_BITS  holding R at acceptance and decrementing in the same cycle as each tick.
REQ-031 SHALL drive ticks_left = 0 in IDLE, in DONE, after abort and after reset.
REQ-032 SHALL, without the macro TICK_SCHED_STATUS_EN, omit the ticks_left port and its logic, leaving all other behaviour identical.

Verification
REQ-033 SHALL cover: period = 3, repeat = 2 -> ticks 3 and 6 cycles after acceptance, done 7 cycles after acceptance, cmd_ready high 8 cycles after acceptance.
REQ-034 SHALL cover: period = 1, repeat = 4 -> ticks on 4 consecutive cycles, then one done pulse.
REQ-035 SHALL cover: period = 0 or repeat = 0 offered -> cmd_err pulses once, busy stays 0, and no tick occurs.
REQ-036 SHALL cover: period = 5, repeat = 3, abort 7 cycles after acceptance -> exactly 1 tick, no done, cmd_ready high the next cycle.
REQ-037 SHALL cover: n_rst pulsed low mid-RUN -> all outputs 0 immediately, and a new command with period = 15, repeat = 1 gives a tick after 15 cycles.
REQ-038 SHALL cover: cmd_valid held high during RUN -> no second command is accepted until the cycle after done.

Source files
------------

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - periodic tick generator: emits R ticks spaced P cycles apart per command
// Optional feature macro: TICK_SCHED_STATUS_EN adds the ticks_left status output.
module tick_scheduler #(
   parameter int NUM_CNT_BITS = 4,
   parameter int NUM_REP_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [NUM_CNT_BITS-1:0] cmd_period,
   input  logic [NUM_REP_BITS-1:0] cmd_repeat,
   input  logic                    abort,
   output logic                    tick,
   output logic                    busy,
   output logic                    done,
`ifdef TICK_SCHED_STATUS_EN
   output logic [NUM_REP_BITS-1:0] ticks_left,
`endif
   output logic                    cmd_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]              state_q, state_nx;
   logic [NUM_CNT_BITS-1:0] per_q, per_nx;
   logic [NUM_REP_BITS-1:0] rep_q, rep_nx;
   // Phase within the current period, 1..P; the cycle showing P carries the tick.
   logic [NUM_CNT_BITS-1:0] ph_q, ph_nx;
   // Number of ticks already launched for the running command.
   logic [NUM_REP_BITS-1:0] tcnt_q, tcnt_nx;
   logic                    tick_nx, done_nx, err_nx, ready_nx, busy_nx;
`ifdef TICK_SCHED_STATUS_EN
   logic [NUM_REP_BITS-1:0] left_nx;
`endif

   // Next-state logic; every output is computed one cycle ahead so it can be registered.
   always_comb begin
      state_nx = state_q;
      per_nx   = per_q;
      rep_nx   = rep_q;
      ph_nx    = ph_q;
      tcnt_nx  = tcnt_q;
      tick_nx  = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
`ifdef TICK_SCHED_STATUS_EN
      left_nx  = ticks_left;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_period == '0 || cmd_repeat == '0) begin
                  err_nx = 1'b1;
               end else begin
                  // Acceptance edge counts as the first cycle of the first period,
                  // so a period of 1 ticks immediately in the next cycle.
                  state_nx = RUN;
                  per_nx   = cmd_period;
                  rep_nx   = cmd_repeat;
                  ph_nx    = NUM_CNT_BITS'(1);
                  tick_nx  = (cmd_period == NUM_CNT_BITS'(1));
                  tcnt_nx  = NUM_REP_BITS'(tick_nx);
`ifdef TICK_SCHED_STATUS_EN
                  left_nx  = cmd_repeat - NUM_REP_BITS'(tick_nx);
`endif
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_nx = IDLE;
               ph_nx    = '0;
               tcnt_nx  = '0;
`ifdef TICK_SCHED_STATUS_EN
               left_nx  = '0;
`endif
            end else if (tick && tcnt_q == rep_q) begin
               state_nx = DONE;
               done_nx  = 1'b1;
               ph_nx    = '0;
               tcnt_nx  = '0;
`ifdef TICK_SCHED_STATUS_EN
               left_nx  = '0;
`endif
            end else begin
               // Compare before incrementing so P = all-ones never overflows.
               ph_nx = (ph_q == per_q) ? NUM_CNT_BITS'(1) : ph_q + NUM_CNT_BITS'(1);
               if (ph_nx == per_q) begin
                  tick_nx = 1'b1;
                  tcnt_nx = tcnt_q + NUM_REP_BITS'(1);
`ifdef TICK_SCHED_STATUS_EN
                  left_nx = ticks_left - NUM_REP_BITS'(1);
`endif
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      ready_nx = (state_nx == IDLE);
      busy_nx  = (state_nx == RUN);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         per_q      <= '0;
         rep_q      <= '0;
         ph_q       <= '0;
         tcnt_q     <= '0;
         tick       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cmd_err    <= 1'b0;
         cmd_ready  <= 1'b0;
`ifdef TICK_SCHED_STATUS_EN
         ticks_left <= '0;
`endif
      end else begin
         state_q    <= state_nx;
         per_q      <= per_nx;
         rep_q      <= rep_nx;
         ph_q       <= ph_nx;
         tcnt_q     <= tcnt_nx;
         tick       <= tick_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         cmd_err    <= err_nx;
         cmd_ready  <= ready_nx;
`ifdef TICK_SCHED_STATUS_EN
         ticks_left <= left_nx;
`endif
      end
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized self-checking bench for tick_scheduler
module tb_tick_scheduler;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_period;
   logic [3:0] cmd_repeat;
   logic       abort;
   logic       tick;
   logic       busy;
   logic       done;
   logic       cmd_err;
`ifdef TICK_SCHED_STATUS_EN
   logic [3:0] ticks_left;
`endif

   tick_scheduler #(.NUM_CNT_BITS(4), .NUM_REP_BITS(4)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_period (cmd_period),
      .cmd_repeat (cmd_repeat),
      .abort      (abort),
      .tick       (tick),
      .busy       (busy),
      .done       (done),
`ifdef TICK_SCHED_STATUS_EN
      .ticks_left (ticks_left),
`endif
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a command is described by its acceptance cycle and timing.
   int cyc        = 0;
   int acc_c      = 0;
   int per_m      = 1;
   int rep_m      = 1;
   int last_c     = 0;
   int stop_c     = 0;
   int ready_from = 0;
   int err_cyc    = -1;
   bit has_cmd    = 1'b0;
   bit has_done   = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic check_zero();
      check("rst_tick", int'(tick), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_err", int'(cmd_err), 0);
      check("rst_ready", int'(cmd_ready), 0);
   endtask

   task automatic check_outputs();
      bit e_busy, e_tick, e_done, e_ready, e_err;
      e_busy  = has_cmd && cyc > acc_c && cyc <= stop_c;
      e_tick  = e_busy && ((cyc - acc_c) % per_m == 0);
      e_done  = has_cmd && has_done && cyc == last_c + 1;
      e_ready = cyc >= ready_from;
      e_err   = cyc == err_cyc;
      check("tick", int'(tick), int'(e_tick));
      check("busy", int'(busy), int'(e_busy));
      check("done", int'(done), int'(e_done));
      check("cmd_ready", int'(cmd_ready), int'(e_ready));
      check("cmd_err", int'(cmd_err), int'(e_err));
`ifdef TICK_SCHED_STATUS_EN
      check("ticks_left", int'(ticks_left), e_busy ? rep_m - (cyc - acc_c) / per_m : 0);
`endif
   endtask

   // One clock cycle: drive inputs, advance the model, then check the next cycle.
   task automatic step(input int v, input int p, input int r, input int ab);
      cmd_valid  = v[0];
      cmd_period = p[3:0];
      cmd_repeat = r[3:0];
      abort      = ab[0];
      if (cyc >= ready_from && v[0]) begin
         if (p[3:0] == 0 || r[3:0] == 0) begin
            err_cyc = cyc + 1;
         end else begin
            has_cmd    = 1'b1;
            has_done   = 1'b1;
            acc_c      = cyc;
            per_m      = p[3:0];
            rep_m      = r[3:0];
            last_c     = acc_c + rep_m * per_m;
            stop_c     = last_c;
            ready_from = last_c + 2;
         end
      end else if (ab[0] && has_cmd && cyc > acc_c && cyc <= stop_c) begin
         stop_c     = cyc;
         has_done   = 1'b0;
         ready_from = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, $urandom_range(0, 15), $urandom_range(0, 15), 0);
   endtask

   // Asynchronous reset pulse taken from mid-cycle.
   task automatic pulse_reset();
      n_rst = 1'b0;
      #1;
      check_zero();
      cmd_valid = 1'b0;
      abort     = 1'b0;
      @(posedge clk);
      cyc++;
      @(posedge clk);
      cyc++;
      #1;
      check_zero();
      n_rst      = 1'b1;
      has_cmd    = 1'b0;
      has_done   = 1'b0;
      err_cyc    = -1;
      ready_from = cyc + 1;
   endtask

   initial begin
      n_rst      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_period = '0;
      cmd_repeat = '0;
      abort      = 1'b0;
      @(posedge clk);
      cyc++;
      @(posedge clk);
      cyc++;
      #1;
      check_zero();
      n_rst      = 1'b1;
      ready_from = cyc + 1;
      idle(2);

      // period 3, repeat 2
      step(1, 3, 2, 0);
      idle(9);
      // period 1, repeat 4
      step(1, 1, 4, 0);
      idle(7);
      // illegal commands
      step(1, 0, 3, 0);
      idle(2);
      step(1, 4, 0, 0);
      idle(2);
      // period 5, repeat 3, abort seven cycles after acceptance
      step(1, 5, 3, 0);
      idle(6);
      step(0, 5, 3, 1);
      idle(4);
      // reset mid-run, then maximum period
      step(1, 4, 5, 0);
      idle(6);
      pulse_reset();
      idle(1);
      step(1, 15, 1, 0);
      idle(18);
      // cmd_valid held high while running
      step(1, 2, 3, 0);
      for (int i = 0; i < 14; i++) step(1, 3, 1, 0);
      idle(6);
      // accept with simultaneous abort in IDLE, abort in DONE
      step(1, 2, 1, 1);
      idle(2);
      step(0, 0, 0, 1);
      idle(2);
      // maximum period, repeat 2
      step(1, 15, 2, 0);
      idle(33);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) == 0) ? 1 : 0,
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 15),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4),
              ($urandom_range(0, 24) == 0) ? 1 : 0);
         if (i == 700) pulse_reset();
      end
      idle(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
